// File: rtl/counter_seq.sv
// Command sequencer for a counter block: turns LOAD/UP/DOWN/WAIT commands into
// cycle-exact en/dn/load/data control, one command at a time.
module counter_seq #(
    parameter int WIDTH = 4,
    parameter int ARG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    input  logic [ARG_W-1:0] cmd_arg,
    output logic             cmd_ready,
    input  logic             abort,
    output logic             en,
    output logic             dn,
    output logic             load,
    output logic [WIDTH-1:0] data,
    output logic             done,
    output logic             aborted
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;
    localparam logic [1:0] OP_WAIT = 2'b11;

    state_t           r_state;
    logic [1:0]       r_op;
    logic [ARG_W-1:0] r_rem;
    logic             r_en;
    logic             r_dn;
    logic             r_load;
    logic [WIDTH-1:0] r_data;
    logic             r_done;
    logic             r_aborted;
    logic             w_accept;

    assign cmd_ready = (r_state == S_IDLE);
    assign w_accept  = cmd_valid && cmd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_op      <= OP_LOAD;
            r_rem     <= '0;
            r_en      <= 1'b0;
            r_dn      <= 1'b0;
            r_load    <= 1'b0;
            r_data    <= '0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op <= cmd_op;
                        if (cmd_op == OP_LOAD) begin
                            r_state <= S_EXEC;
                            r_load  <= 1'b1;
                            r_data  <= cmd_arg[WIDTH-1:0];
                            r_rem   <= '0;
                        end else if (cmd_arg == '0) begin
                            // Zero-length command completes without touching controls.
                            r_done <= 1'b1;
                        end else begin
                            r_state <= S_EXEC;
                            r_en    <= (cmd_op == OP_UP) || (cmd_op == OP_DOWN);
                            r_dn    <= (cmd_op == OP_DOWN);
                            r_rem   <= cmd_arg - ARG_W'(1);
                        end
                    end
                end
                S_EXEC: begin
                    if (abort) begin
                        r_state   <= S_IDLE;
                        r_en      <= 1'b0;
                        r_dn      <= 1'b0;
                        r_load    <= 1'b0;
                        r_aborted <= 1'b1;
                    end else if (r_rem == '0) begin
                        r_state <= S_IDLE;
                        r_en    <= 1'b0;
                        r_dn    <= 1'b0;
                        r_load  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_rem <= r_rem - ARG_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign en      = r_en;
    assign dn      = r_dn;
    assign load    = r_load;
    assign data    = r_data;
    assign done    = r_done;
    assign aborted = r_aborted;

endmodule

// File: tb/tb_counter_seq.sv
// Directed bench for counter_seq with a behavioural counter attached to its
// control outputs; expected values are hand-computed.
module tb_counter_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_arg = 8'd0;
    logic       cmd_ready;
    logic       abort = 1'b0;
    logic       en, dn, load, done, aborted;
    logic [3:0] data;
    logic [3:0] count;

    int total = 0;
    int bad = 0;

    counter_seq #(.WIDTH(4), .ARG_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
        .cmd_ready(cmd_ready), .abort(abort),
        .en(en), .dn(dn), .load(load), .data(data),
        .done(done), .aborted(aborted)
    );

    always #5 clk = ~clk;

    // Counter being sequenced: load wins, otherwise count up/down on en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     count <= 4'd0;
        else if (load)  count <= data;
        else if (en)    count <= dn ? count - 4'd1 : count + 4'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a command for one edge; returns in the cycle after acceptance.
    task automatic send(input logic [1:0] op, input logic [7:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        step();
        cmd_valid = 1'b0;
        cmd_arg   = 8'd0;
    endtask

    initial begin
        #2;
        check("rst_en", en, 0);
        check("rst_load", load, 0);
        check("rst_data", data, 0);
        check("rst_done", done, 0);
        #10 rst_n = 1'b1;
        step();
        check("rst_ready", cmd_ready, 1);

        // LOAD 7
        send(2'b00, 8'd7);
        check("ld7_load", load, 1);
        check("ld7_data", data, 7);
        check("ld7_en", en, 0);
        check("ld7_ready", cmd_ready, 0);
        step();
        check("ld7_load_off", load, 0);
        check("ld7_done", done, 1);
        check("ld7_count", count, 7);

        // UP 5 accepted in the done cycle
        send(2'b01, 8'd5);
        for (int i = 0; i < 5; i++) begin
            check("up5_en", en, 1);
            check("up5_dn", dn, 0);
            check("up5_nodone", done, 0);
            step();
        end
        check("up5_en_off", en, 0);
        check("up5_done", done, 1);
        check("up5_count", count, 12);

        // UP 10 wraps
        send(2'b01, 8'd10);
        for (int i = 0; i < 10; i++) begin
            check("up10_en", en, 1);
            step();
        end
        check("up10_done", done, 1);
        check("up10_count", count, 6);

        // LOAD 9 then DOWN 3 in its done cycle
        send(2'b00, 8'd9);
        step();
        check("ld9_done", done, 1);
        check("ld9_count", count, 9);
        send(2'b10, 8'd3);
        for (int i = 0; i < 3; i++) begin
            check("dn3_en", en, 1);
            check("dn3_dn", dn, 1);
            check("dn3_load", load, 0);
            step();
        end
        check("dn3_done", done, 1);
        check("dn3_dn_off", dn, 0);
        check("dn3_count", count, 6);

        // UP 0: done next cycle, no control
        send(2'b01, 8'd0);
        check("up0_done", done, 1);
        check("up0_en", en, 0);
        check("up0_ready", cmd_ready, 1);

        // WAIT 4
        send(2'b11, 8'd4);
        for (int i = 0; i < 4; i++) begin
            check("wait_en", en, 0);
            check("wait_load", load, 0);
            check("wait_ready", cmd_ready, 0);
            check("wait_nodone", done, 0);
            step();
        end
        check("wait_done", done, 1);
        check("wait_count", count, 6);

        // LOAD 0, then UP 10 aborted at edge ending the 3rd en cycle
        send(2'b00, 8'd0);
        step();
        check("ld0_count", count, 0);
        send(2'b01, 8'd10);
        step();
        step();
        check("ab_en3", en, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("ab_en_off", en, 0);
        check("ab_aborted", aborted, 1);
        check("ab_nodone", done, 0);
        check("ab_count", count, 3);
        check("ab_ready", cmd_ready, 1);
        step();
        check("ab_pulse_end", aborted, 0);
        check("ab_nodone2", done, 0);

        // Stray abort in IDLE does not block acceptance
        abort = 1'b1;
        send(2'b00, 8'd2);
        abort = 1'b0;
        check("idleab_load", load, 1);
        check("idleab_data", data, 2);
        step();
        check("idleab_done", done, 1);
        check("idleab_aborted", aborted, 0);
        check("idleab_count", count, 2);

        // Reset during DOWN 8 after 2 steps
        send(2'b10, 8'd8);
        step();
        step();
        check("rdn_en", en, 1);
        check("rdn_count", count, 0);
        #2 rst_n = 1'b0;
        #1;
        check("rdn_en0", en, 0);
        check("rdn_dn0", dn, 0);
        check("rdn_data0", data, 0);
        check("rdn_ready", cmd_ready, 1);
        #10 rst_n = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            check("rdn_nodone", done, 0);
            check("rdn_noabort", aborted, 0);
            check("rdn_ready2", cmd_ready, 1);
            step();
        end

        // LOAD 5 after reset
        send(2'b00, 8'd5);
        check("ld5_load", load, 1);
        check("ld5_data", data, 5);
        step();
        check("ld5_done", done, 1);
        check("ld5_count", count, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/counter_seq.md
# counter_seq

Command-driven sequencer for the `counter` block (`clk`, `rst_n`, `en`, `dn`, `load`, `data`, `count`). Accepts load/up/down/wait commands over a valid/ready handshake and drives the counter's control pins cycle-exactly, one command at a time. Sits between a host/test controller and one `counter` instance, replacing hand-timed control of `en`/`dn`/`load`.

## Interface
- `WIDTH`, 4, counter width; width of `data`
- `ARG_W`, 8, command argument width; must be >= `WIDTH`
- `clk`  in  1  clock; all state changes on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  command present
- `cmd_op`  in  2  00 LOAD, 01 UP, 10 DOWN, 11 WAIT
- `cmd_arg`  in  ARG_W  LOAD: value (low `WIDTH` bits); UP/DOWN/WAIT: cycle count N
- `cmd_ready`  out  1  sequencer idle, command accepted when `cmd_valid & cmd_ready`
- `abort`  in  1  terminate the executing command
- `en`  out  1  to counter `en`
- `dn`  out  1  to counter `dn`
- `load`  out  1  to counter `load`
- `data`  out  WIDTH  to counter `data`
- `done`  out  1  one-cycle pulse: command completed normally
- `aborted`  out  1  one-cycle pulse: command terminated by `abort`

## Operation
- States: IDLE, EXEC. Registers: `op`, `rem` (ARG_W bits), all outputs except `cmd_ready`.
- `cmd_ready` = (state == IDLE), combinational. `cmd_valid` ignored when not ready; `cmd_op`/`cmd_arg` sampled only at the accepting edge.
- Reset (async): state IDLE, `rem`=0, `en`=`dn`=`load`=0, `data`=0, `done`=`aborted`=0; `cmd_ready`=1.
- Accept LOAD: -> EXEC, `load`=1, `data`=`cmd_arg[WIDTH-1:0]`, `rem`=0. `en`=`dn`=0.
- Accept UP, N>0: -> EXEC, `en`=1, `dn`=0, `rem`=N-1.
- Accept DOWN, N>0: -> EXEC, `en`=1, `dn`=1, `rem`=N-1.
- Accept WAIT, N>0: -> EXEC, controls all 0, `rem`=N-1.
- Accept UP/DOWN/WAIT with N=0: stay IDLE, `done`=1 next cycle, no control asserted.
- EXEC edge, `abort`=0, `rem`!=0: `rem`-1, controls held.
- EXEC edge, `abort`=0, `rem`==0: -> IDLE, `en`=`dn`=`load`=0, `done`=1.
- EXEC edge, `abort`=1: -> IDLE, controls 0, `aborted`=1, `done`=0 (abort wins over normal completion on the same edge).
- `abort` in IDLE ignored; command accepted on same edge as a stray `abort`.
- `dn` is 1 only while `en`=1 for DOWN. `load` and `en` never both 1.
- `data` holds last loaded value until next LOAD; never changes outside LOAD acceptance.
- `done`/`aborted` are otherwise 0; never both 1.
- Counter wrap is the counter's business (modulo 2^WIDTH); the sequencer does no range checks.

## Timing
- Acceptance edge E0; controls visible in cycle after E0.
- LOAD: `load`=1 for exactly 1 cycle; counter samples at E1; `done` high in cycle after E1.
- UP/DOWN N>0: `en`=1 for exactly N cycles; counter takes exactly N steps; `done` in cycle N+1 after E0.
- WAIT N>0: N idle control cycles, then `done`.
- `done`/`aborted` cycle is IDLE with `cmd_ready`=1; a command accepted then drives controls in the following cycle. Back-to-back cost: 1 gap cycle per command.
- Abort sampled at edge Ek (k-th EXEC cycle ended): controls were high for k cycles, so counter has taken k steps; controls 0 from next cycle, `aborted` pulsed that cycle.
- Reset mid-EXEC: all outputs 0 immediately (async), command discarded, no `done`/`aborted`.

## Test plan
- Reset: assert `rst_n`=0 mid-clock -> `en`,`dn`,`load`,`data`,`done`,`aborted` = 0 immediately, `cmd_ready`=1 after release.
- LOAD 7 -> `load`=1, `data`=7 for one cycle; `done` next cycle; counter `count`=7.
- After LOAD 7, UP 5 -> `en`=1, `dn`=0 for 5 cycles, `count`=12, `done` in 6th cycle after acceptance; then UP 10 -> `count` wraps to 6.
- DOWN 3 accepted in the `done` cycle of a LOAD 9 -> `en`=`dn`=1 for 3 cycles starting one cycle after acceptance, `count`=6; then UP 0 -> `done` next cycle, `en` never 1; WAIT 4 -> 4 idle cycles, `count` unchanged, `done` in 5th cycle.
- UP 10 from `count`=0, `abort` sampled at edge ending 3rd `en` cycle -> `en` drops, `aborted`=1 one cycle, no `done`, `count`=3; `abort` in IDLE with `cmd_valid`=1 -> command still accepted.
- `rst_n`=0 during DOWN 8 after 2 steps -> outputs 0 at once, no `done`; after release `cmd_ready`=1 and a new LOAD 5 executes normally.
